// File: rtl/alu_exec_stage.sv
// alu_exec_stage: single-issue execute/write-back stage feeding a 16x8 register file.
// Optional macro ALU_FORWARD_EN: bypass wb_data into hazarding operands instead of stalling.
module alu_exec_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [3:0] in_dst,
  input  logic [3:0] in_src0,
  input  logic [3:0] in_src1,
  input  logic [7:0] in_imm,
  output logic [3:0] rf_src0,
  output logic [3:0] rf_src1,
  input  logic [7:0] rf_data0,
  input  logic [7:0] rf_data1,
  output logic       rf_we,
  output logic [3:0] rf_dst,
  output logic [7:0] rf_data,
  output logic       flag_z,
  output logic       flag_c,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;

  typedef struct packed {
    logic              wr;
    logic              upd;
    logic              c;
    logic [DATA_W-1:0] res;
  } alu_res_t;

  function automatic alu_res_t alu_eval(input logic [3:0]        op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [DATA_W-1:0] imm);
    alu_res_t          r;
    logic [DATA_W:0]   wide;
    r    = '0;
    wide = '0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        r.wr  = 1'b1;
        r.upd = 1'b1;
        r.c   = wide[DATA_W];
        r.res = wide[DATA_W-1:0];
      end
      OP_SUB, OP_CMP: begin
        // Bit 8 of the 9-bit difference is the borrow (A < B).
        wide  = {1'b0, a} - {1'b0, b};
        r.wr  = (op == OP_SUB);
        r.upd = 1'b1;
        r.c   = wide[DATA_W];
        r.res = wide[DATA_W-1:0];
      end
      OP_AND: begin
        r.wr  = 1'b1;
        r.upd = 1'b1;
        r.res = a & b;
      end
      OP_OR: begin
        r.wr  = 1'b1;
        r.upd = 1'b1;
        r.res = a | b;
      end
      OP_XOR: begin
        r.wr  = 1'b1;
        r.upd = 1'b1;
        r.res = a ^ b;
      end
      OP_LDI: begin
        r.wr  = 1'b1;
        r.res = imm;
      end
      OP_MOV: begin
        r.wr  = 1'b1;
        r.res = a;
      end
      OP_ADDI: begin
        wide  = {1'b0, a} + {1'b0, imm};
        r.wr  = 1'b1;
        r.upd = 1'b1;
        r.c   = wide[DATA_W];
        r.res = wide[DATA_W-1:0];
      end
      OP_SHL: begin
        r.wr  = 1'b1;
        r.upd = 1'b1;
        r.c   = a[DATA_W-1];
        r.res = {a[DATA_W-2:0], 1'b0};
      end
      OP_SHR: begin
        r.wr  = 1'b1;
        r.upd = 1'b1;
        r.c   = a[0];
        r.res = {1'b0, a[DATA_W-1:1]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic reads_a(input logic [3:0] op);
    return (op inside {[OP_ADD:OP_XOR], [OP_MOV:OP_SHR]});
  endfunction

  function automatic logic reads_b(input logic [3:0] op);
    return (op inside {[OP_ADD:OP_XOR], OP_CMP});
  endfunction

  logic              vld_p1;
  logic [ADDR_W-1:0] dst_p1;
  logic [DATA_W-1:0] data_p1;
  logic              z_p1;
  logic              c_p1;

  logic              haz_a_p0;
  logic              haz_b_p0;
  logic              stall_p0;
  logic              accept_p0;
  logic [DATA_W-1:0] opa_p0;
  logic [DATA_W-1:0] opb_p0;
  alu_res_t          ev_p0;

  // Stage 0: operand fetch, hazard detection, ALU evaluation
  assign rf_src0  = in_src0;
  assign rf_src1  = in_src1;
  assign haz_a_p0 = vld_p1 & reads_a(in_op) & (dst_p1 == in_src0);
  assign haz_b_p0 = vld_p1 & reads_b(in_op) & (dst_p1 == in_src1);

`ifdef ALU_FORWARD_EN
  assign opa_p0   = haz_a_p0 ? data_p1 : rf_data0;
  assign opb_p0   = haz_b_p0 ? data_p1 : rf_data1;
  assign stall_p0 = 1'b0;
`else
  assign opa_p0   = rf_data0;
  assign opb_p0   = rf_data1;
  assign stall_p0 = haz_a_p0 | haz_b_p0;
`endif

  assign in_ready  = ~rst & ~stall_p0;
  assign accept_p0 = in_valid & in_ready;
  assign ev_p0     = alu_eval(in_op, opa_p0, opb_p0, in_imm);

  // Stage 1: write-back register and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      z_p1   <= 1'b0;
      c_p1   <= 1'b0;
    end else begin
      vld_p1 <= accept_p0 & ev_p0.wr;
      if (accept_p0 && ev_p0.upd) begin
        z_p1 <= (ev_p0.res == '0);
        c_p1 <= ev_p0.c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      dst_p1  <= in_dst;
      data_p1 <= ev_p0.res;
    end
  end

  // Outputs are forced low during reset so an in-flight write is dropped at once.
  assign rf_we   = vld_p1 & ~rst;
  assign busy    = vld_p1 & ~rst;
  assign rf_dst  = rst ? '0 : dst_p1;
  assign rf_data = rst ? '0 : data_p1;
  assign flag_z  = z_p1 & ~rst;
  assign flag_c  = c_p1 & ~rst;

endmodule
